// File: rtl/regfile_write_scheduler.sv
// Writeback scheduler: grants up to two of three producers per cycle with rotating priority
// and drives the register file's two write ports from a registered output stage.
module regfile_write_scheduler #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic [2:0]              req_valid,
  input  logic [3*ADDR_W-1:0]     req_addr,
  input  logic [3*DATA_W-1:0]     req_data,
  output logic [2:0]              req_ready,
  output logic [ADDR_W-1:0]       RW1,
  output logic [ADDR_W-1:0]       RW2,
  output logic [DATA_W-1:0]       BusW1,
  output logic [DATA_W-1:0]       BusW2,
  output logic                    enable_write1,
  output logic                    enable_write2,
  output logic [(1<<ADDR_W)-1:0]  pending_mask,
  output logic [15:0]             conflict_count
);

  logic [ADDR_W-1:0] addr_arr [3];
  logic [DATA_W-1:0] data_arr [3];

  logic [1:0]        rr_q, rr_d;
  logic              g1_found, g2_found, deferral;
  logic [1:0]        g1_idx, g2_idx;
  logic [2:0]        grant;

  logic              en1_q, en2_q;
  logic [ADDR_W-1:0] rw1_q, rw2_q;
  logic [DATA_W-1:0] busw1_q, busw2_q;
  logic [15:0]       conflict_q;

  function automatic logic [1:0] next_idx(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Walk the three requesters once in rotating order starting at rr_q.
  always_comb begin
    logic [1:0]        idx;
    logic [ADDR_W-1:0] g1_addr;
    g1_found = 1'b0;
    g1_idx   = 2'd0;
    g1_addr  = '0;
    g2_found = 1'b0;
    g2_idx   = 2'd0;
    deferral = 1'b0;
    idx      = rr_q;
    for (int k = 0; k < 3; k++) begin
      if (!stall && req_valid[idx]) begin
        if (!g1_found) begin
          g1_found = 1'b1;
          g1_idx   = idx;
          g1_addr  = addr_arr[idx];
        end else if (!g2_found) begin
          // Same-address requester waits so the two ports never collide.
          if (addr_arr[idx] == g1_addr) begin
            deferral = 1'b1;
          end else begin
            g2_found = 1'b1;
            g2_idx   = idx;
          end
        end
      end
      idx = next_idx(idx);
    end
  end

  always_comb begin
    grant = 3'b000;
    if (g1_found) grant[g1_idx] = 1'b1;
    if (g2_found) grant[g2_idx] = 1'b1;
    req_ready = reset ? 3'b000 : grant;
  end

  always_comb begin
    rr_d = rr_q;
    if (g2_found) begin
      rr_d = next_idx(g2_idx);
    end else if (g1_found) begin
      rr_d = next_idx(g1_idx);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q       <= 2'd0;
      en1_q      <= 1'b0;
      en2_q      <= 1'b0;
      rw1_q      <= '0;
      rw2_q      <= '0;
      busw1_q    <= '0;
      busw2_q    <= '0;
      conflict_q <= 16'd0;
    end else begin
      rr_q  <= rr_d;
      en1_q <= g1_found;
      en2_q <= g2_found;
      if (g1_found) begin
        rw1_q   <= addr_arr[g1_idx];
        busw1_q <= data_arr[g1_idx];
      end
      if (g2_found) begin
        rw2_q   <= addr_arr[g2_idx];
        busw2_q <= data_arr[g2_idx];
      end
      if (deferral && conflict_q != 16'hFFFF) begin
        conflict_q <= conflict_q + 16'd1;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    if (en1_q) pending_mask[rw1_q] = 1'b1;
    if (en2_q) pending_mask[rw2_q] = 1'b1;
  end

  assign RW1            = rw1_q;
  assign RW2            = rw2_q;
  assign BusW1          = busw1_q;
  assign BusW2          = busw2_q;
  assign enable_write1  = en1_q;
  assign enable_write2  = en2_q;
  assign conflict_count = conflict_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed, table-driven bench for regfile_write_scheduler with a behavioural register file.
module tb_regfile_write_scheduler;
  localparam int DW = 32;
  localparam int AW = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            stall;
  logic [2:0]      req_valid;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_data;
  logic [2:0]      req_ready;
  logic [AW-1:0]   RW1, RW2;
  logic [DW-1:0]   BusW1, BusW2;
  logic            enable_write1, enable_write2;
  logic [15:0]     pending_mask;
  logic [15:0]     conflict_count;

  int checks = 0;
  int errors = 0;

  regfile_write_scheduler #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .RW1            (RW1),
    .RW2            (RW2),
    .BusW1          (BusW1),
    .BusW2          (BusW2),
    .enable_write1  (enable_write1),
    .enable_write2  (enable_write2),
    .pending_mask   (pending_mask),
    .conflict_count (conflict_count)
  );

  always #5 clock = ~clock;

  // Register file: commits enabled ports at each rising edge; not cleared by reset.
  logic [DW-1:0] rf [16];
  logic          rf_init;
  always @(posedge clock) begin
    if (rf_init) begin
      for (int r = 0; r < 16; r++) rf[r] <= '0;
    end else begin
      if (enable_write1) rf[RW1] <= BusW1;
      if (enable_write2) rf[RW2] <= BusW2;
    end
  end

  typedef struct {
    logic        stall;
    logic [2:0]  valid;
    logic [3:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  ready;
    logic        en1, en2;
    logic [3:0]  rw1, rw2;
    logic [31:0] b1, b2;
    logic [15:0] mask, cc;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] v, input logic [3:0] a0, a1, a2,
                       input logic [31:0] d0, d1, d2);
    stall     = s;
    req_valid = v;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
  endtask

  initial begin
    //          stall valid   a0     a1     a2     d0        d1        d2
    //          ready  en1   en2   rw1    rw2    b1        b2        mask       cc
    vecs[0]  = '{1'b0, 3'b001, 4'd1, 4'd0, 4'd0, 32'd16, 32'd0, 32'd0,
                 3'b001, 1'b1, 1'b0, 4'd1, 4'd0, 32'd16, 32'd0, 16'h0002, 16'd0};
    vecs[1]  = '{1'b0, 3'b100, 4'd0, 4'd0, 4'd7, 32'd0, 32'd0, 32'h77,
                 3'b100, 1'b1, 1'b0, 4'd7, 4'd0, 32'h77, 32'd0, 16'h0080, 16'd0};
    vecs[2]  = '{1'b0, 3'b011, 4'd1, 4'd2, 4'd0, 32'd16, 32'd2, 32'd0,
                 3'b011, 1'b1, 1'b1, 4'd1, 4'd2, 32'd16, 32'd2, 16'h0006, 16'd0};
    vecs[3]  = '{1'b0, 3'b111, 4'd3, 4'd4, 4'd5, 32'h30, 32'h40, 32'h50,
                 3'b101, 1'b1, 1'b1, 4'd5, 4'd3, 32'h50, 32'h30, 16'h0028, 16'd0};
    vecs[4]  = '{1'b0, 3'b111, 4'd3, 4'd4, 4'd5, 32'h30, 32'h40, 32'h50,
                 3'b110, 1'b1, 1'b1, 4'd4, 4'd5, 32'h40, 32'h50, 16'h0030, 16'd0};
    vecs[5]  = '{1'b0, 3'b111, 4'd3, 4'd4, 4'd5, 32'h30, 32'h40, 32'h50,
                 3'b011, 1'b1, 1'b1, 4'd3, 4'd4, 32'h30, 32'h40, 16'h0018, 16'd0};
    vecs[6]  = '{1'b0, 3'b011, 4'd2, 4'd2, 4'd0, 32'd32, 32'd64, 32'd0,
                 3'b001, 1'b1, 1'b0, 4'd2, 4'd4, 32'd32, 32'h40, 16'h0004, 16'd1};
    vecs[7]  = '{1'b0, 3'b010, 4'd0, 4'd2, 4'd0, 32'd0, 32'd64, 32'd0,
                 3'b010, 1'b1, 1'b0, 4'd2, 4'd4, 32'd64, 32'h40, 16'h0004, 16'd1};
    vecs[8]  = '{1'b1, 3'b111, 4'd8, 4'd9, 4'd10, 32'h80, 32'h90, 32'hA0,
                 3'b000, 1'b0, 1'b0, 4'd2, 4'd4, 32'd64, 32'h40, 16'h0000, 16'd1};
    vecs[9]  = '{1'b0, 3'b111, 4'd8, 4'd9, 4'd10, 32'h80, 32'h90, 32'hA0,
                 3'b101, 1'b1, 1'b1, 4'd10, 4'd8, 32'hA0, 32'h80, 16'h0500, 16'd1};
    vecs[10] = '{1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0,
                 3'b000, 1'b0, 1'b0, 4'd10, 4'd8, 32'hA0, 32'h80, 16'h0000, 16'd1};
    vecs[11] = '{1'b0, 3'b111, 4'd6, 4'd6, 4'd6, 32'd1, 32'd2, 32'd3,
                 3'b010, 1'b1, 1'b0, 4'd6, 4'd8, 32'd2, 32'h80, 16'h0040, 16'd2};
    vecs[12] = '{1'b0, 3'b101, 4'd6, 4'd0, 4'd6, 32'd1, 32'd0, 32'd3,
                 3'b100, 1'b1, 1'b0, 4'd6, 4'd8, 32'd3, 32'h80, 16'h0040, 16'd3};
    vecs[13] = '{1'b0, 3'b001, 4'd6, 4'd0, 4'd0, 32'd1, 32'd0, 32'd0,
                 3'b001, 1'b1, 1'b0, 4'd6, 4'd8, 32'd1, 32'h80, 16'h0040, 16'd3};
    vecs[14] = '{1'b0, 3'b111, 4'd11, 4'd9, 4'd9, 32'hB0, 32'h91, 32'h92,
                 3'b011, 1'b1, 1'b1, 4'd9, 4'd11, 32'h91, 32'hB0, 16'h0A00, 16'd4};
    vecs[15] = '{1'b0, 3'b100, 4'd0, 4'd0, 4'd9, 32'd0, 32'd0, 32'h92,
                 3'b100, 1'b1, 1'b0, 4'd9, 4'd11, 32'h92, 32'hB0, 16'h0200, 16'd4};

    // Reset with all three requesting: nothing may be accepted.
    rf_init = 1'b1;
    reset   = 1'b1;
    drive(1'b0, 3'b111, 4'd1, 4'd2, 4'd3, 32'd1, 32'd2, 32'd3);
    repeat (2) @(posedge clock);
    #1;
    check("reset ready", req_ready, 3'b000);
    check("reset en1", enable_write1, 1'b0);
    check("reset en2", enable_write2, 1'b0);
    check("reset rw1", RW1, 4'd0);
    check("reset busw2", BusW2, 32'd0);
    check("reset mask", pending_mask, 16'h0000);
    check("reset cc", conflict_count, 16'd0);
    drive(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0);
    #1;
    reset   = 1'b0;
    rf_init = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].stall, vecs[i].valid, vecs[i].a0, vecs[i].a1, vecs[i].a2,
            vecs[i].d0, vecs[i].d1, vecs[i].d2);
      #2;
      check($sformatf("v%0d ready", i), req_ready, vecs[i].ready);
      @(posedge clock);
      #1;
      check($sformatf("v%0d en1", i), enable_write1, vecs[i].en1);
      check($sformatf("v%0d en2", i), enable_write2, vecs[i].en2);
      check($sformatf("v%0d rw1", i), RW1, vecs[i].rw1);
      check($sformatf("v%0d rw2", i), RW2, vecs[i].rw2);
      check($sformatf("v%0d busw1", i), BusW1, vecs[i].b1);
      check($sformatf("v%0d busw2", i), BusW2, vecs[i].b2);
      check($sformatf("v%0d mask", i), pending_mask, vecs[i].mask);
      check($sformatf("v%0d cc", i), conflict_count, vecs[i].cc);
    end

    // Idle cycle lets the last write commit, then inspect the register file.
    drive(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0);
    @(posedge clock);
    #1;
    check("rf[1]", rf[1], 32'd16);
    check("rf[2] deferred wins", rf[2], 32'd64);
    check("rf[5]", rf[5], 32'h50);
    check("rf[6]", rf[6], 32'd1);
    check("rf[7]", rf[7], 32'h77);
    check("rf[9]", rf[9], 32'h92);
    check("rf[10]", rf[10], 32'hA0);
    check("rf[11]", rf[11], 32'hB0);

    // Grant requester 1 (moves the pointer to 2), then reset before the write commits.
    drive(1'b0, 3'b010, 4'd0, 4'd12, 4'd0, 32'd0, 32'hC0, 32'd0);
    #2;
    check("pre-reset ready", req_ready, 3'b010);
    @(posedge clock);
    #1;
    check("pre-reset en1", enable_write1, 1'b1);
    check("pre-reset rw1", RW1, 4'd12);
    #1;
    reset = 1'b1;
    #1;
    check("async en1", enable_write1, 1'b0);
    check("async en2", enable_write2, 1'b0);
    check("async mask", pending_mask, 16'h0000);
    check("async cc", conflict_count, 16'd0);
    check("async rw1", RW1, 4'd0);
    check("async busw1", BusW1, 32'd0);
    check("async ready", req_ready, 3'b000);
    drive(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("flushed rf[12]", rf[12], 32'd0);
    check("post-reset en1", enable_write1, 1'b0);

    // Pointer must be back at 0: requesters 0 and 1 win.
    drive(1'b0, 3'b111, 4'd13, 4'd14, 4'd15, 32'hD0, 32'hE0, 32'hF0);
    #2;
    check("post-reset ready", req_ready, 3'b011);
    @(posedge clock);
    #1;
    check("post-reset rw1", RW1, 4'd13);
    check("post-reset rw2", RW2, 4'd14);
    check("post-reset mask", pending_mask, 16'h6000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Writeback scheduler for the 16-entry, 32-bit, dual-write-port register file. It accepts write requests from three producers (0 = ALU, 1 = memory load, 2 = multiply/divide unit). Each cycle it grants up to two of them with rotating priority and drives the register file's two write ports from a registered output stage. It also publishes a pending-write mask so the issue controller can stall reads of registers whose writes are still in flight.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 4, register address width (2^ADDR_W registers)
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall  in  1  when 1, no request is granted this cycle
- req_valid  in  3  per-requester write request
- req_addr  in  3*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W]
- req_data  in  3*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
- req_ready  out  3  combinational; 1 = request i accepted at this rising edge
- RW1, RW2  out  ADDR_W each  write addresses for register file ports 1 and 2
- BusW1, BusW2  out  DATA_W each  write data for ports 1 and 2
- enable_write1, enable_write2  out  1 each  write enables for ports 1 and 2
- pending_mask  out  2^ADDR_W  bit r = 1 while the output stage holds a write to register r
- conflict_count  out  16  saturating count of same-address deferrals

## Operation
- Round-robin pointer rr_ptr ∈ {0,1,2}; scan order is rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
- First grant (G1): first valid requester in scan order.
- Second grant (G2): next valid requester after G1 in scan order whose address ≠ G1's address.
  - A valid requester skipped only because its address equals G1's is deferred. Each cycle with ≥1 deferral adds 1 to conflict_count (saturates at 0xFFFF).
- stall=1: no grants, req_ready=0, rr_ptr unchanged, output stage loads idle (enables 0).
- req_ready[i] = 1 iff i is G1 or G2. Requesters hold valid/addr/data stable until ready is seen.
- rr_ptr update: if any grant, rr_ptr ← (index of last grant made + 1) mod 3. With no grant it is unchanged.
- Output stage, at every edge:
  - Port 1 ← G1: RW1/BusW1 take G1's addr/data, enable_write1=1.
  - Port 2 ← G2: RW2/BusW2 take G2's addr/data, enable_write2=1.
  - A missing grant clears that port's enable. Its addr/data hold their previous values.
- Ports 1 and 2 never carry the same address with both enables set.
- pending_mask = one-hot(RW1) gated by enable_write1, OR one-hot(RW2) gated by enable_write2.
- Register 0 has no special treatment.

## Timing
- Reset values: enables 0, RW1/RW2 0, BusW1/BusW2 0, pending_mask 0, conflict_count 0, rr_ptr 0.
  - req_ready is 0 while reset is asserted.
- Latency: a request accepted at edge N is on the write port during cycle N..N+1. The register file commits it at edge N+1, and a read in cycle N+1 returns the new value.
- Throughput: 2 writes/cycle sustained when the addresses differ.
- Reset asserted between acceptance and commit: the accepted write is dropped. Producers treat reset as a pipeline flush.
- Simultaneous requests from all three: the third waits at least one cycle. The round-robin pointer guarantees service within 2 cycles of any contention pattern.
- Requests to the same address in the same cycle: the earlier one in scan order writes first; the deferred one writes on a later cycle, so the deferred value wins.

## Test plan
- Reset, then req_valid=001, addr 1, data 16 → req_ready=001. One cycle later RW1=1, BusW1=16, enable_write1=1, enable_write2=0, pending_mask=0x0002. Register 1 then reads 16.
- req_valid=011 with addrs 1 and 2, data 16 and 2, rr_ptr=0 → both ready. Next cycle port 1 = (1,16) and port 2 = (2,2). rr_ptr becomes 2.
- req_valid=111 held for 3 cycles with addrs 3, 4, 5 → grants cycle by cycle are {0,1}, {2,0}, {1,2}. No requester waits more than 2 cycles.
- req_valid=011, both addr 2, data 32 and 64 → only requester 0 is granted, conflict_count=1. Next cycle requester 1 is granted. Register 2 finally holds 64.
- stall=1 with req_valid=111 → req_ready=000 and enables 0 next cycle. On releasing stall, grants resume at the same rr_ptr.
- Assert reset asynchronously mid-cycle right after a grant → enables, pending_mask and conflict_count drop to 0 immediately, the register file receives no write, and rr_ptr=0 after release.
